// File: rtl/copro_result_buffer.sv
// Result buffer between the non-stallable coprocessor ALU and the CV-X-IF result channel.
// Captures one-cycle ALU result pulses in a circular FIFO and throttles issue so it can never overflow.
module copro_result_buffer #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned Depth          = 4,
    parameter type         hartid_t       = logic,
    parameter type         id_t           = logic,
    parameter bit          ProtocolChecks = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       issue_fire_i,
    output logic                       issue_ready_o,
    input  logic                       alu_valid_i,
    input  logic [XLEN-1:0]            alu_result_i,
    input  hartid_t                    alu_hartid_i,
    input  id_t                        alu_id_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic                       alu_we_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [XLEN-1:0]            result_data_o,
    output hartid_t                    result_hartid_o,
    output id_t                        result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic                       result_we_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       overflow_o
);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    localparam logic [PW-1:0] LAST_C  = PW'(Depth - 1);

    typedef struct packed {
        logic [XLEN-1:0] data;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t          mem_q [Depth];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            pending_q;
    logic            overflow_q;
    logic            full, push, pop;
    logic [CW:0]     credit;

    assign full     = (count_q == DEPTH_C);
    assign pop      = result_valid_o && result_ready_i;
    assign push     = alu_valid_i && (!full || pop);
    assign wr_entry = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                        rd: alu_rd_i, we: alu_we_i};

    // Credit counts results already stored plus the one still in flight in the ALU.
    assign credit        = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    assign issue_ready_o = (credit < {1'b0, DEPTH_C});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= issue_fire_i;
            if (push) begin
                mem_q[wptr_q] <= wr_entry;
                wptr_q        <= (wptr_q == LAST_C) ? '0 : wptr_q + 1'b1;
            end
            if (pop) rptr_q <= (rptr_q == LAST_C) ? '0 : rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (alu_valid_i && !push) overflow_q <= 1'b1;
        end
    end

    // Head is read straight from storage, so a new entry is visible only after it is written.
    assign head            = mem_q[rptr_q];
    assign result_valid_o  = (count_q != '0);
    assign result_data_o   = head.data;
    assign result_hartid_o = head.hartid;
    assign result_id_o     = head.id;
    assign result_rd_o     = head.rd;
    assign result_we_o     = head.we;
    assign count_o         = count_q;
    assign overflow_o      = overflow_q;

    generate
        if (ProtocolChecks) begin : g_chk
            a_issue_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
                issue_fire_i |-> issue_ready_o);
            a_alu_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
                alu_valid_i == pending_q);
        end
    endgenerate
endmodule
